// File: rtl/avalon_uart_rx_master_if.sv
// Avalon-MM read-side bus between the UART receive master and the UART data register.
interface avalon_uart_rx_master_if #(
   parameter int ADDR_W = 1
);
   logic [31:0]       readdata_in;
   logic              waitrequest_in;
   logic              chipselect_out;
   logic [ADDR_W-1:0] address_out;
   logic              read_n_out;
   logic              write_n_out;

   modport master (
      input  readdata_in, waitrequest_in,
      output chipselect_out, address_out, read_n_out, write_n_out
   );

   modport slave (
      output readdata_in, waitrequest_in,
      input  chipselect_out, address_out, read_n_out, write_n_out
   );
endinterface

// File: rtl/avalon_uart_rx_master.sv
// Interrupt-driven Avalon-MM read master: drains UART bytes, packs them big-endian into
// instruction words and buffers them in a valid/ready FIFO. Optional feature: AVM_WAIT_TIMEOUT_EN.
//
// state | meaning
// IDLE  | bus idle, waiting for irq_in with FIFO space
// READ  | bus read of the UART data register, held through waitrequest
// STORE | shift latched byte into the assembler, push completed words
module avalon_uart_rx_master #(
   parameter int ADDR_W         = 1,
   parameter int DATA_ADDR      = 0,
   parameter int RAVAIL_LSB     = 16,
   parameter int RAVAIL_W       = 16,
   parameter int BYTE_W         = 8,
   parameter int INSTR_BYTES    = 2,
   parameter int FIFO_DEPTH     = 4,
   parameter int TIMEOUT_CYCLES = 255,
   localparam int INSTR_W       = INSTR_BYTES * BYTE_W,
   localparam int CNT_W         = $clog2(FIFO_DEPTH) + 1
) (
   input  logic                   clock_n_in,
   input  logic                   reset_in,
   avalon_uart_rx_master_if.master avm,
   input  logic                   irq_in,
   output logic                   ready_out,
   output logic [INSTR_W-1:0]     instruction_out,
   output logic                   instr_valid_out,
   input  logic                   instr_ready_in,
   output logic [CNT_W-1:0]       fifo_count_out,
   output logic                   error_out
);
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int BC_W  = $clog2(INSTR_BYTES + 1);
   localparam logic [BC_W-1:0]  BC_LAST = BC_W'(INSTR_BYTES);
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

   typedef enum logic [1:0] {IDLE, READ, STORE} state_t;
   state_t state_q, state_nx;

   logic [BYTE_W-1:0]         byte_q;
   logic                      ravail_q;
   logic [BC_W-1:0]           bcnt_q, bcnt_nx, bcnt_inc;
   logic [INSTR_W-1:0]        asm_q, asm_nx;
   logic [INSTR_W+BYTE_W-1:0] shifted;
   logic                      push, pop, tmo;
   logic                      cs_q, rd_n_q, rdy_q;
   logic [ADDR_W-1:0]         addr_q;
   logic [INSTR_W-1:0]        mem [FIFO_DEPTH];
   logic [PTR_W-1:0]          wr_ptr, rd_ptr;
   logic [CNT_W-1:0]          cnt_q, cnt_nx;
   logic                      unused_rd;

   assign unused_rd = ^avm.readdata_in;
   assign pop       = (cnt_q != '0) && instr_ready_in;
   assign bcnt_inc  = bcnt_q + 1'b1;
   assign shifted   = {asm_q, byte_q};

   always_comb begin
      state_nx = state_q;
      bcnt_nx  = bcnt_q;
      asm_nx   = asm_q;
      push     = 1'b0;
      case (state_q)
         IDLE: begin
            if (irq_in && (cnt_q < DEPTH_C)) state_nx = READ;
         end
         READ: begin
            if (tmo) begin
               state_nx = IDLE;
               bcnt_nx  = '0;
               asm_nx   = '0;
            end else if (!avm.waitrequest_in) begin
               state_nx = STORE;
            end
         end
         STORE: begin
            asm_nx = shifted[INSTR_W-1:0];
            if (bcnt_inc == BC_LAST) begin
               push    = 1'b1;
               bcnt_nx = '0;
            end else begin
               bcnt_nx = bcnt_inc;
            end
            // Room check uses the occupancy after this edge's push and pop.
            if (push)
               state_nx = (ravail_q && (pop || (cnt_q < DEPTH_C - 1'b1))) ? READ : IDLE;
            else
               state_nx = (ravail_q && (pop || (cnt_q < DEPTH_C))) ? READ : IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(negedge clock_n_in or posedge reset_in) begin
      if (reset_in) begin
         state_q  <= IDLE;
         byte_q   <= '0;
         ravail_q <= 1'b0;
         bcnt_q   <= '0;
         asm_q    <= '0;
         cs_q     <= 1'b0;
         addr_q   <= '0;
         rd_n_q   <= 1'b1;
         rdy_q    <= 1'b1;
      end else begin
         state_q <= state_nx;
         bcnt_q  <= bcnt_nx;
         asm_q   <= asm_nx;
         if ((state_q == READ) && !avm.waitrequest_in) begin
            byte_q   <= avm.readdata_in[BYTE_W-1:0];
            ravail_q <= |avm.readdata_in[RAVAIL_LSB +: RAVAIL_W];
         end
         cs_q   <= (state_nx == READ);
         addr_q <= (state_nx == READ) ? ADDR_W'(DATA_ADDR) : '0;
         rd_n_q <= (state_nx != READ);
         rdy_q  <= (state_nx == IDLE);
      end
   end

   always_comb begin
      cnt_nx = cnt_q;
      if (push && !pop)      cnt_nx = cnt_q + 1'b1;
      else if (!push && pop) cnt_nx = cnt_q - 1'b1;
   end

   always_ff @(negedge clock_n_in or posedge reset_in) begin
      if (reset_in) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt_q  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         cnt_q <= cnt_nx;
      end
   end

   always_ff @(negedge clock_n_in) begin
      if (push) mem[wr_ptr] <= shifted[INSTR_W-1:0];
   end

`ifdef AVM_WAIT_TIMEOUT_EN
   localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [WD_W-1:0] wd_q;
   logic            err_q;

   // Down-counter reloaded outside READ; terminal count on a stalled edge aborts the read.
   assign tmo = (state_q == READ) && avm.waitrequest_in && (wd_q == '0);

   always_ff @(negedge clock_n_in or posedge reset_in) begin
      if (reset_in) begin
         wd_q  <= '0;
         err_q <= 1'b0;
      end else begin
         if (state_q != READ)                         wd_q <= WD_W'(TIMEOUT_CYCLES - 1);
         else if (avm.waitrequest_in && wd_q != '0)   wd_q <= wd_q - 1'b1;
         if (tmo) err_q <= 1'b1;
      end
   end
   assign error_out = err_q;
`else
   localparam int unused_timeout = TIMEOUT_CYCLES;
   assign tmo       = 1'b0;
   assign error_out = 1'b0;
`endif

   assign avm.chipselect_out = cs_q;
   assign avm.address_out    = addr_q;
   assign avm.read_n_out     = rd_n_q;
   assign avm.write_n_out    = 1'b1;
   assign ready_out          = rdy_q;
   assign fifo_count_out     = cnt_q;
   assign instr_valid_out    = (cnt_q != '0);
   assign instruction_out    = instr_valid_out ? mem[rd_ptr] : '0;
endmodule

// File: tb/tb_avalon_uart_rx_master.sv
// Randomised bench: UART slave model with a byte queue and a word scoreboard for the packer/FIFO.
module tb_avalon_uart_rx_master;
   localparam int ADDR_W    = 1;
   localparam int DATA_ADDR = 1;
   localparam int DEPTH     = 4;
   localparam int TMO       = 8;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        irq = 1'b0;
   logic        instr_ready = 1'b0;
   logic [15:0] instruction;
   logic        instr_valid;
   logic [2:0]  fifo_count;
   logic        ready;
   logic        error;

   avalon_uart_rx_master_if #(.ADDR_W(ADDR_W)) avm ();

   avalon_uart_rx_master #(
      .ADDR_W(ADDR_W), .DATA_ADDR(DATA_ADDR), .FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)
   ) dut (
      .clock_n_in     (clk),
      .reset_in       (rst),
      .avm            (avm),
      .irq_in         (irq),
      .ready_out      (ready),
      .instruction_out(instruction),
      .instr_valid_out(instr_valid),
      .instr_ready_in (instr_ready),
      .fifo_count_out (fifo_count),
      .error_out      (error)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   logic [7:0]  uart_q [$];
   logic [7:0]  part_q [$];
   logic [15:0] exp_w [$];
   int          exp_t [$];
   int          cyc = 0, nreads = 0, nwords = 0, ws_left = 0, ws_lo = 0, ws_hi = 0;
   int          pop_at = -1, last_xfer = -100, stuck_edges = 0;
   bit          rdy_rand = 0, rdy_fixed = 0, pop_on_push = 0, stuck = 0, b2b_chk = 0;
   bit          prev_more = 0, err_exp = 0;
   logic [15:0] last_pop = '0;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
      end
   endtask

   task automatic send(input logic [7:0] b);
      uart_q.push_back(b);
      irq = 1'b1;
   endtask

   task automatic tick();
      int vis;
      logic [7:0] b;
      @(posedge clk);
      cyc++;
      vis = 0;
      foreach (exp_t[i]) if (exp_t[i] <= cyc) vis++;
      check("count", 32'(fifo_count), 32'(vis));
      check("valid", 32'(instr_valid), 32'(vis != 0));
      check("instr", 32'(instruction), (vis != 0) ? 32'(exp_w[0]) : 32'(0));
      check("error", 32'(error), 32'(err_exp));
      check("write_n", 32'(avm.write_n_out), 32'(1));
      if (avm.chipselect_out) begin
         check("rd_n_busy", 32'(avm.read_n_out), 32'(0));
         check("addr_busy", 32'(avm.address_out), 32'(DATA_ADDR));
         check("ready_busy", 32'(ready), 32'(0));
      end else begin
         check("rd_n_idle", 32'(avm.read_n_out), 32'(1));
         check("addr_idle", 32'(avm.address_out), 32'(0));
      end

      instr_ready = rdy_rand ? 1'($urandom_range(0, 1)) : (rdy_fixed || (pop_at == cyc));
      if (instr_ready && vis != 0) begin
         last_pop = instruction;
         void'(exp_w.pop_front());
         void'(exp_t.pop_front());
      end

      avm.waitrequest_in = 1'b0;
      avm.readdata_in    = $urandom;
      if (avm.chipselect_out && !avm.read_n_out) begin
         if (stuck) begin
            avm.waitrequest_in = 1'b1;
            stuck_edges++;
`ifdef AVM_WAIT_TIMEOUT_EN
            if (stuck_edges == TMO) begin
               err_exp = 1'b1;
               part_q.delete();
               stuck = 0;
            end
`endif
         end else if (ws_left > 0) begin
            avm.waitrequest_in = 1'b1;
            ws_left--;
         end else begin
            check("read_with_data", 32'(uart_q.size() != 0), 32'(1));
            b = (uart_q.size() != 0) ? uart_q.pop_front() : 8'h00;
            avm.readdata_in = {16'(uart_q.size()), 8'($urandom), b};
            nreads++;
            if (b2b_chk && prev_more) check("b2b", 32'(cyc - last_xfer), 32'(2));
            last_xfer = cyc;
            prev_more = (uart_q.size() != 0);
            part_q.push_back(b);
            if (part_q.size() == 2) begin
               exp_w.push_back({part_q[0], part_q[1]});
               exp_t.push_back(cyc + 2);
               part_q.delete();
               nwords++;
               if (pop_on_push) pop_at = cyc + 1;
            end
            ws_left = $urandom_range(ws_lo, ws_hi);
         end
      end
      irq = (uart_q.size() != 0);
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic pulse_reset();
      rst = 1'b1;
      #1;
      check("rst_cs", 32'(avm.chipselect_out), 32'(0));
      check("rst_rd_n", 32'(avm.read_n_out), 32'(1));
      check("rst_ready", 32'(ready), 32'(1));
      check("rst_count", 32'(fifo_count), 32'(0));
      check("rst_instr", 32'(instruction), 32'(0));
      check("rst_error", 32'(error), 32'(0));
      exp_w.delete(); exp_t.delete(); part_q.delete();
      err_exp = 0; ws_left = 0; stuck = 0; prev_more = 0;
      @(posedge clk);
      @(posedge clk);
      rst = 1'b0;
   endtask

   initial begin
      int r0;
      bit seen;
      avm.readdata_in    = '0;
      avm.waitrequest_in = 1'b0;

      // Reset state with irq low
      repeat (2) @(posedge clk);
      #1;
      check("t1_cs", 32'(avm.chipselect_out), 32'(0));
      check("t1_rd_n", 32'(avm.read_n_out), 32'(1));
      check("t1_wr_n", 32'(avm.write_n_out), 32'(1));
      check("t1_ready", 32'(ready), 32'(1));
      check("t1_count", 32'(fifo_count), 32'(0));
      check("t1_valid", 32'(instr_valid), 32'(0));
      @(posedge clk);
      rst = 1'b0;
      run(3);

      // Four characters with one wait state each, consumer always ready
      rdy_fixed = 1; ws_lo = 1; ws_hi = 1; ws_left = 1; r0 = nreads;
      send(8'h0A); send(8'h09); send(8'h08); send(8'h07);
      run(40);
      check("t2_reads", 32'(nreads - r0), 32'(4));
      check("t2_words", 32'(nwords), 32'(2));
      check("t2_last", 32'(last_pop), 32'h0807);
      check("t2_ready", 32'(ready), 32'(1));

      // Zero-wait back-to-back reads
      ws_lo = 0; ws_hi = 0; ws_left = 0; b2b_chk = 1;
      for (int i = 0; i < 6; i++) send(8'($urandom));
      run(40);
      b2b_chk = 0;

      // Backpressure: ten characters, consumer stalled
      rdy_fixed = 0; ws_hi = 2; r0 = nreads;
      for (int i = 0; i < 10; i++) send(8'($urandom));
      run(60);
      check("t3_reads8", 32'(nreads - r0), 32'(8));
      check("t3_full", 32'(fifo_count), 32'(DEPTH));
      check("t3_bus_idle", 32'(avm.chipselect_out), 32'(0));
      pop_at = cyc + 1;
      run(60);
      check("t3_reads10", 32'(nreads - r0), 32'(10));
      check("t3_full2", 32'(fifo_count), 32'(DEPTH));
      rdy_fixed = 1;
      run(30);
      check("t3_drain", 32'(fifo_count), 32'(0));

      // Push and pop on the same edge at occupancy 2
      rdy_fixed = 0;
      for (int i = 0; i < 4; i++) send(8'($urandom));
      run(40);
      check("t4_pre", 32'(fifo_count), 32'(2));
      pop_on_push = 1;
      send(8'hC1); send(8'hC2);
      run(40);
      pop_on_push = 0;
      check("t4_post", 32'(fifo_count), 32'(2));
      rdy_fixed = 1;
      run(20);

      // Reset in the middle of the second byte's read
      ws_lo = 0; ws_hi = 0; ws_left = 0;
      send(8'h0A);
      run(20);
      stuck = 1; stuck_edges = 0;
      send(8'h55);
      seen = 0;
      for (int i = 0; i < 20 && !seen; i++) begin
         tick();
         seen = avm.chipselect_out;
      end
      check("t5_in_read", 32'(seen), 32'(1));
      tick();
      uart_q.delete();
      irq = 1'b0;
      pulse_reset();
      send(8'h09); send(8'h08);
      run(30);
      check("t5_word", 32'(last_pop), 32'h0908);

`ifdef AVM_WAIT_TIMEOUT_EN
      // Waitrequest watchdog with a partial word pending
      send(8'h31);
      run(20);
      stuck = 1; stuck_edges = 0;
      send(8'h32); send(8'h33);
      for (int i = 0; i < 40 && !error; i++) tick();
      check("t6_err", 32'(error), 32'(1));
      check("t6_edges", 32'(stuck_edges), 32'(TMO));
      check("t6_cs", 32'(avm.chipselect_out), 32'(0));
      check("t6_ready", 32'(ready), 32'(1));
      run(40);
      check("t6_word", 32'(last_pop), 32'h3233);
      check("t6_sticky", 32'(error), 32'(1));
      pulse_reset();
      run(5);
`endif

      // Random traffic: bursts, wait states and consumer stalls
      rdy_fixed = 0; rdy_rand = 1; ws_lo = 0; ws_hi = 3;
      for (int i = 0; i < 1500; i++) begin
         if (uart_q.size() == 0 && $urandom_range(0, 7) == 0) begin
            int n = $urandom_range(1, 9);
            for (int k = 0; k < n; k++) send(8'($urandom));
         end
         tick();
      end
      rdy_rand = 0; rdy_fixed = 1;
      run(120);
      check("end_uart_empty", 32'(uart_q.size()), 32'(0));
      check("end_count", 32'(fifo_count), 32'(0));
      check("end_ready", 32'(ready), 32'(1));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
